// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-setting controller.
// Holds the mode_o width and the RUN / SET_HOUR / SET_MIN state encoding.
package clock_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] RUN      = 2'd0;
    localparam logic [MODE_W-1:0] SET_HOUR = 2'd1;
    localparam logic [MODE_W-1:0] SET_MIN  = 2'd2;

    // Mode-button step: RUN -> SET_HOUR -> SET_MIN -> RUN.
    function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] cur);
        case (cur)
            RUN:      next_mode = SET_HOUR;
            SET_HOUR: next_mode = SET_MIN;
            default:  next_mode = RUN;
        endcase
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_repeat.sv
// Increment-button front end: rising-edge detection plus optional auto-repeat.
// Optional feature macro: AUTO_REPEAT_EN (hold-to-repeat). Without it, exactly
// one press_o per button press and no repeat counters exist.
module btn_repeat #(
    parameter int unsigned REPEAT_DLY = 5,
    parameter int unsigned REPEAT_PER = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    logic btn_q;
    logic valid_q;
    logic rise;

    // Previous-cycle level; valid_q ensures only post-reset samples form an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            btn_q   <= btn_i;
            valid_q <= 1'b1;
        end
    end

    assign rise = valid_q & btn_i & ~btn_q;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // cnt_q == 0 means no armed hold; it is loaded with 1 on a press so that a
    // button already high when reset released never starts repeating.
    logic [CNT_W-1:0] cnt_q;
    logic             rpt_phase_q;
    logic             rpt_fire;

    // Repeat pulse: first after REPEAT_DLY held cycles, then every REPEAT_PER.
    always_comb begin
        rpt_fire = 1'b0;
        if (btn_i && !rise && (cnt_q != '0)) begin
            if (rpt_phase_q) rpt_fire = (cnt_q == CNT_W'(REPEAT_PER));
            else             rpt_fire = (cnt_q == CNT_W'(REPEAT_DLY));
        end
    end

    // Hold-duration counter, restarted by each press and each repeat pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            rpt_phase_q <= 1'b0;
        end else if (!btn_i) begin
            cnt_q       <= '0;
            rpt_phase_q <= 1'b0;
        end else if (rise) begin
            cnt_q       <= CNT_W'(1);
            rpt_phase_q <= 1'b0;
        end else if (cnt_q != '0) begin
            if (rpt_fire) begin
                cnt_q       <= CNT_W'(1);
                rpt_phase_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign press_o = rise | rpt_fire;
`else
    assign press_o = rise;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller for a digital clock: mode FSM, increment/clear
// strobes to the time counter, display blinking and set-mode inactivity timeout.
// Optional feature macro: AUTO_REPEAT_EN (auto-repeat of a held increment button).
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TPS        = 10,
    parameter int unsigned REPEAT_DLY = 5,
    parameter int unsigned REPEAT_PER = 2,
    parameter int unsigned TIMEOUT_S  = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              btn_mode_i,
    input  logic              btn_inc_i,
    output logic              run_en_o,
    output logic              inc_hour_o,
    output logic              inc_min_o,
    output logic              clr_sec_o,
    output logic              blank_hour_o,
    output logic              blank_min_o,
    output logic [MODE_W-1:0] mode_o
);

    localparam int unsigned IDLE_LIMIT = TIMEOUT_S * TPS;
    localparam int unsigned IDLE_W     = $clog2(IDLE_LIMIT + 1);
    localparam int unsigned BLINK_W    = (TPS > 1) ? $clog2(TPS) : 1;

    logic [MODE_W-1:0]  state_q, state_d;
    logic               mode_q, mode_valid_q;
    logic               mode_rise;
    logic               inc_press;
    logic               btn_event;
    logic               timeout;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               hour_d, min_d, clr_d;
    logic               hour_q, min_q, clr_q;

    btn_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_inc_btn (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (btn_inc_i),
        .press_o (inc_press)
    );

    // Mode-button edge detector; only levels sampled after reset form an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q       <= 1'b0;
            mode_valid_q <= 1'b0;
        end else begin
            mode_q       <= btn_mode_i;
            mode_valid_q <= 1'b1;
        end
    end

    assign mode_rise = mode_valid_q & btn_mode_i & ~mode_q;
    assign btn_event = mode_rise | inc_press;
    assign timeout   = (state_q != RUN) && (idle_q == IDLE_W'(IDLE_LIMIT)) && !btn_event;

    // Next state, strobes and counters; a mode rise outranks any increment.
    always_comb begin
        state_d = state_q;
        hour_d  = 1'b0;
        min_d   = 1'b0;
        clr_d   = 1'b0;
        if (mode_rise) begin
            state_d = next_mode(state_q);
            clr_d   = (state_q == SET_MIN);
        end else if (timeout) begin
            state_d = RUN;
            clr_d   = 1'b1;
        end else begin
            hour_d = (state_q == SET_HOUR) && inc_press;
            min_d  = (state_q == SET_MIN) && inc_press;
        end

        if ((state_q == RUN) || btn_event || timeout) idle_d = '0;
        else                                          idle_d = idle_q + IDLE_W'(1);

        if (state_q == RUN)                     blink_d = '0;
        else if (blink_q == BLINK_W'(TPS - 1))  blink_d = '0;
        else                                    blink_d = blink_q + BLINK_W'(1);
    end

    // State, counters and registered strobes; reset drops any pending strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            idle_q  <= '0;
            blink_q <= '0;
            hour_q  <= 1'b0;
            min_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            blink_q <= blink_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            clr_q   <= clr_d;
        end
    end

    assign run_en_o     = (state_q == RUN);
    assign mode_o       = state_q;
    assign inc_hour_o   = hour_q;
    assign inc_min_o    = min_q;
    assign clr_sec_o    = clr_q;
    // Blanking follows the live increment level so the value stays visible while pressing.
    assign blank_hour_o = (state_q == SET_HOUR) && (blink_q >= BLINK_W'(TPS / 2)) && !btn_inc_i;
    assign blank_min_o  = (state_q == SET_MIN)  && (blink_q >= BLINK_W'(TPS / 2)) && !btn_inc_i;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: cycle-level behavioural model plus
// directed scenarios with literal expectations. Honours AUTO_REPEAT_EN.
module tb_time_set_ctrl;

    localparam int TPS        = 10;
    localparam int REPEAT_DLY = 5;
    localparam int REPEAT_PER = 2;
    localparam int TIMEOUT_S  = 3;

    logic       clk_i      = 1'b0;
    logic       rst_i      = 1'b0;
    logic       btn_mode_i = 1'b0;
    logic       btn_inc_i  = 1'b0;
    logic       run_en_o, inc_hour_o, inc_min_o, clr_sec_o, blank_hour_o, blank_min_o;
    logic [1:0] mode_o;

    time_set_ctrl #(
        .TPS        (TPS),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER),
        .TIMEOUT_S  (TIMEOUT_S)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .btn_mode_i   (btn_mode_i),
        .btn_inc_i    (btn_inc_i),
        .run_en_o     (run_en_o),
        .inc_hour_o   (inc_hour_o),
        .inc_min_o    (inc_min_o),
        .clr_sec_o    (clr_sec_o),
        .blank_hour_o (blank_hour_o),
        .blank_min_o  (blank_min_o),
        .mode_o       (mode_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_hour = 0;
    int cnt_min  = 0;
    int cnt_clr  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0/1/2, idle and blink counts, hold length in cycles.
    int m_mode = 0, m_prev_mode = 0, m_prev_inc = 0, m_valid = 0;
    int m_hold = 0, m_idle = 0, m_blink = 0;
    int m_hs = 0, m_ms = 0, m_cs = 0;

    initial begin
        forever begin
            @(posedge clk_i or posedge rst_i);
            if (rst_i) begin
                m_mode = 0; m_prev_mode = 0; m_prev_inc = 0; m_valid = 0;
                m_hold = 0; m_idle = 0; m_blink = 0;
                m_hs = 0; m_ms = 0; m_cs = 0;
            end else begin
                int mrise, irise, rpt, press, evt, tmo, nm, e;
                mrise = (m_valid != 0 && btn_mode_i && m_prev_mode == 0) ? 1 : 0;
                irise = (m_valid != 0 && btn_inc_i && m_prev_inc == 0) ? 1 : 0;
                if (!btn_inc_i)      m_hold = 0;
                else if (irise != 0) m_hold = 1;
                else if (m_hold > 0) m_hold = m_hold + 1;
                rpt = 0;
`ifdef AUTO_REPEAT_EN
                if (m_hold >= 2) begin
                    e   = m_hold - 1 - REPEAT_DLY;
                    rpt = (e >= 0 && (e % REPEAT_PER) == 0) ? 1 : 0;
                end
`else
                e = 0;
`endif
                press = (irise != 0 || rpt != 0) ? 1 : 0;
                evt   = (mrise != 0 || press != 0) ? 1 : 0;
                tmo   = (m_mode != 0 && m_idle == TIMEOUT_S * TPS && evt == 0) ? 1 : 0;
                m_hs  = (m_mode == 1 && press != 0 && mrise == 0) ? 1 : 0;
                m_ms  = (m_mode == 2 && press != 0 && mrise == 0) ? 1 : 0;
                m_cs  = ((m_mode == 2 && mrise != 0) || tmo != 0) ? 1 : 0;
                nm    = (mrise != 0) ? (m_mode + 1) % 3 : ((tmo != 0) ? 0 : m_mode);
                m_idle  = (m_mode == 0 || evt != 0 || tmo != 0) ? 0 : m_idle + 1;
                m_blink = (m_mode == 0) ? 0 : (m_blink + 1) % TPS;
                m_mode  = nm;
                m_prev_mode = btn_mode_i ? 1 : 0;
                m_prev_inc  = btn_inc_i ? 1 : 0;
                m_valid = 1;
            end
        end
    end

    // Per-cycle compare of all outputs against the model, mid-cycle.
    initial begin
        forever begin
            logic [7:0] exp_v, act_v;
            logic       bh, bm;
            @(negedge clk_i);
            bh = (m_mode == 1 && m_blink >= TPS / 2 && !btn_inc_i);
            bm = (m_mode == 2 && m_blink >= TPS / 2 && !btn_inc_i);
            exp_v = {m_mode[1:0], (m_mode == 0), (m_hs != 0), (m_ms != 0), (m_cs != 0), bh, bm};
            act_v = {mode_o, run_en_o, inc_hour_o, inc_min_o, clr_sec_o, blank_hour_o, blank_min_o};
            check("model_outputs", {24'h0, act_v}, {24'h0, exp_v});
            if (inc_hour_o === 1'b1) cnt_hour++;
            if (inc_min_o  === 1'b1) cnt_min++;
            if (clr_sec_o  === 1'b1) cnt_clr++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance n clock edges; inputs change 3 time units after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #3;
    endtask

    initial begin
        int          h0, m0, c0, k;
        logic [15:0] mask;
        logic [63:0] blank_seq;

        #1 rst_i = 1'b1;
        tick(2);
        rst_i = 1'b0;

        // Idle in RUN after reset.
        tick(20);
        check("idle_mode", {30'h0, mode_o}, 0);
        check("idle_run_en", {31'h0, run_en_o}, 1);
        check("idle_strobes", cnt_hour + cnt_min + cnt_clr, 0);

        // Enter SET_HOUR, single increment.
        btn_mode_i = 1'b1; tick(1);
        check("enter_set_hour", {30'h0, mode_o}, 1);
        btn_mode_i = 1'b0; tick(1);
        h0 = cnt_hour;
        btn_inc_i = 1'b1; tick(1);
        check("inc_hour_pulse", {31'h0, inc_hour_o}, 1);
        btn_inc_i = 1'b0; tick(1);
        check("inc_hour_end", {31'h0, inc_hour_o}, 0);
        check("inc_hour_count", cnt_hour - h0, 1);

        // SET_MIN, 12-cycle hold.
        btn_mode_i = 1'b1; tick(1);
        btn_mode_i = 1'b0;
        check("enter_set_min", {30'h0, mode_o}, 2);
        tick(1);
        btn_inc_i = 1'b1;
        mask = '0;
        for (int h = 1; h <= 12; h++) begin
            tick(1);
            if (inc_min_o === 1'b1) mask[h] = 1'b1;
        end
        btn_inc_i = 1'b0;
`ifdef AUTO_REPEAT_EN
        check("hold_strobe_cycles", {16'h0, mask}, 32'h1542);
`else
        check("hold_strobe_cycles", {16'h0, mask}, 32'h0002);
`endif
        tick(2);

        // SET_MIN -> RUN clears seconds; then simultaneous mode+inc in SET_HOUR.
        btn_mode_i = 1'b1; tick(1);
        check("exit_clr_sec", {31'h0, clr_sec_o}, 1);
        check("exit_to_run", {30'h0, mode_o}, 0);
        btn_mode_i = 1'b0; tick(1);
        btn_mode_i = 1'b1; tick(1);
        btn_mode_i = 1'b0; tick(1);
        h0 = cnt_hour; m0 = cnt_min;
        btn_mode_i = 1'b1; btn_inc_i = 1'b1; tick(1);
        check("both_mode", {30'h0, mode_o}, 2);
        check("both_no_hour", {31'h0, inc_hour_o}, 0);
        check("both_no_min", {31'h0, inc_min_o}, 0);
        btn_mode_i = 1'b0; btn_inc_i = 1'b0; tick(2);
        check("both_no_strobes", (cnt_hour - h0) + (cnt_min - m0), 0);

        // SET_MIN -> RUN -> SET_HOUR, then inactivity timeout.
        btn_mode_i = 1'b1; tick(1);
        btn_mode_i = 1'b0; tick(1);
        btn_mode_i = 1'b1; tick(1);
        btn_mode_i = 1'b0;
        c0 = cnt_clr;
        blank_seq = '0;
        k = 0;
        while (mode_o === 2'd1 && k < 60) begin
            blank_seq[k] = blank_hour_o;
            k++;
            tick(1);
        end
        check("timeout_cycles", k, 31);
        check("timeout_mode", {30'h0, mode_o}, 0);
        check("timeout_clr", {31'h0, clr_sec_o}, 1);
        check("blank_hour_pattern", blank_seq[31:0], 32'h3E0F83E0);
        tick(1);
        check("timeout_clr_end", {31'h0, clr_sec_o}, 0);
        check("timeout_clr_count", cnt_clr - c0, 1);

        // Reset in the middle of a hold in SET_MIN.
        btn_mode_i = 1'b1; tick(1);
        btn_mode_i = 1'b0; tick(1);
        btn_mode_i = 1'b1; tick(1);
        btn_mode_i = 1'b0; tick(1);
        btn_inc_i = 1'b1; tick(6);
`ifdef AUTO_REPEAT_EN
        check("pre_reset_strobe", {31'h0, inc_min_o}, 1);
`else
        check("pre_reset_strobe", {31'h0, inc_min_o}, 0);
`endif
        rst_i = 1'b1; btn_mode_i = 1'b1;
        #1;
        check("reset_outputs",
              {24'h0, mode_o, run_en_o, inc_hour_o, inc_min_o, clr_sec_o, blank_hour_o, blank_min_o},
              32'h20);
        tick(2);
        rst_i = 1'b0;
        h0 = cnt_hour; m0 = cnt_min; c0 = cnt_clr;
        tick(5);
        check("held_through_reset_mode", {30'h0, mode_o}, 0);
        check("held_through_reset_strobes", (cnt_hour - h0) + (cnt_min - m0) + (cnt_clr - c0), 0);
        btn_mode_i = 1'b0; btn_inc_i = 1'b0; tick(2);
        btn_mode_i = 1'b1; tick(1);
        check("post_reset_mode_edge", {30'h0, mode_o}, 1);
        btn_mode_i = 1'b0; tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
